com_cdc_synch_filt: RTL and testbench
=====================================

Name: com_cdc_synch_filt

Overview:
- Multi-channel input synchroniser with a per-channel glitch filter and edge/event detection, all in the destination clock domain.
- Each of WIDTH asynchronous single-bit inputs passes through a NUM_STAGES flop chain, then a stability filter. A channel's output changes only after its synchronised value has held for FILTER_LEN consecutive cycles.
- Drives filtered levels, one-cycle rise/fall strobes, and sticky per-channel event flags for register readback.
- Used on slow async control/status lines (chip flags, external triggers, test-board switches).

Parameters:
- WIDTH, 8, number of independent channels (>=1).
- NUM_STAGES, 2, synchroniser flops per channel (>=2; elaboration error otherwise).
- FILTER_LEN, 3, consecutive stable cycles required before the output updates (>=1; 1 = no filtering beyond one register).
- RESET_VALUE, '0, WIDTH-bit value loaded into the sync chain and o_data at reset.

Ports:
- i_clk  in  1  destination clock
- i_rst  in  1  synchronous active-high reset
- i_data  in  WIDTH  asynchronous inputs
- i_clear_evt  in  WIDTH  per-channel clear of o_evt_sticky
- o_data  out  WIDTH  synchronised, filtered level
- o_rise  out  WIDTH  one-cycle strobe, filtered 0->1
- o_fall  out  WIDTH  one-cycle strobe, filtered 1->0
- o_evt_sticky  out  WIDTH  set on any filtered edge, held until cleared

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values, applied on the i_clk edge with i_rst=1:
  - every sync stage = RESET_VALUE[ch]
  - o_data = RESET_VALUE
  - filter counters = 0
  - o_rise = o_fall = o_evt_sticky = 0
  - no edge strobes are generated by reset itself
- Reset mid-operation aborts any count in progress; no strobe is emitted.
- Sync chain: per channel, a shift register of NUM_STAGES flops; s_sync[ch] is the last stage. All bits are shifted each cycle, with no enable.
- Filter, per channel. The counter is $clog2(FILTER_LEN+1) bits, unsigned. On each edge:
  - if s_sync == o_data: cnt <= 0
  - else if cnt == FILTER_LEN-1: o_data <= s_sync, cnt <= 0
  - else: cnt <= cnt+1
  - Any return of s_sync to o_data before the count completes resets cnt. Pulses shorter than FILTER_LEN cycles are rejected.
- Latency: a step on i_data that is stable from setup of edge E0 appears on o_data after edge E(NUM_STAGES+FILTER_LEN-1). That is NUM_STAGES+FILTER_LEN cycles (5 at defaults).
- Edge strobes:
  - o_rise[ch] and o_fall[ch] are registered and asserted in the same cycle o_data[ch] changes, for exactly one cycle.
  - At most one of the two is asserted per channel per cycle.
  - The minimum spacing between strobes on a channel is FILTER_LEN cycles.
- Sticky flag:
  - o_evt_sticky[ch] <= (o_evt_sticky[ch] & ~i_clear_evt[ch]) | o_rise_next[ch] | o_fall_next[ch].
  - If set and clear coincide, set wins.
- Channels are fully independent; no cross-channel coherence is guaranteed. Multi-bit buses must not be passed through this block.
- The input is treated as asynchronous; the first sync stage carries the ASYNC_REG attribute.

Test Plan:
- Reset: i_rst=1 for 3 cycles with RESET_VALUE=8'hA5 and i_data=8'h00 -> after release o_data=8'hA5, o_rise=o_fall=o_evt_sticky=0. o_data then falls exactly 5 cycles later; o_fall=8'hA5 pulses for 1 cycle.
- Latency: defaults, i_data[0] steps 0->1 at E0 and holds -> o_data[0]=1 after E4, o_rise[0]=1 only in that cycle, o_evt_sticky[0]=1 from then on.
- Glitch reject: i_data[3] high for 2 cycles then low -> o_data[3], o_rise[3] and o_evt_sticky[3] stay 0. The same stimulus held for 3 cycles -> o_data[3] goes high for exactly 3 cycles and both strobes fire.
- Sticky clear race: o_evt_sticky[1]=1, then i_clear_evt[1]=1 in the same cycle a new o_fall[1] strobe is produced -> o_evt_sticky[1] stays 1. A later clear alone -> 0.
- Independence and reset mid-count: toggle all 8 channels at different offsets, with i_rst asserted during a channel-5 count at cnt=1 -> channel 5 returns to RESET_VALUE[5] with no strobe. The other channels' latency matches the 5-cycle model after release.
- Parameter sweep NUM_STAGES=3, FILTER_LEN=1 -> step latency 4 cycles. A 1-cycle input pulse propagates as a 1-cycle o_data pulse with a rise/fall strobe pair.

Source files
------------

// File: rtl/com_cdc_synch_filt.sv
// Multi-channel async input synchroniser with per-channel stability filter,
// filtered rise/fall strobes and sticky event flags, all in the i_clk domain.
module com_cdc_synch_filt #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      NUM_STAGES  = 2,
  parameter int unsigned      FILTER_LEN  = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_clear_evt,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_evt_sticky
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  generate
    if (NUM_STAGES < 2) begin : g_bad_stages
      $error("com_cdc_synch_filt: NUM_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
      $error("com_cdc_synch_filt: FILTER_LEN must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("com_cdc_synch_filt: WIDTH must be >= 1");
    end
  endgenerate

  // First stage samples truly asynchronous data; keep it tagged for placement.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] chain_q [NUM_STAGES-1];
  logic [WIDTH-1:0] s_sync;

  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic [WIDTH-1:0] evt_q,   evt_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Synchroniser shift chain, shifted every cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RESET_VALUE;
      for (int i = 0; i < int'(NUM_STAGES) - 1; i++) begin
        chain_q[i] <= RESET_VALUE;
      end
    end else begin
      meta_q     <= i_data;
      chain_q[0] <= meta_q;
      for (int i = 1; i < int'(NUM_STAGES) - 1; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign s_sync = chain_q[NUM_STAGES-2];

  // Filter next state: commit a new level only after FILTER_LEN stable cycles.
  always_comb begin
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int ch = 0; ch < int'(WIDTH); ch++) begin
      if (s_sync[ch] == data_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        data_d[ch] = s_sync[ch];
        cnt_d[ch]  = '0;
        rise_d[ch] = s_sync[ch];
        fall_d[ch] = ~s_sync[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
    // A coincident clear loses to a new edge.
    evt_d = (evt_q & ~i_clear_evt) | rise_d | fall_d;
  end

  // Filter state, strobes and sticky flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      for (int ch = 0; ch < int'(WIDTH); ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      for (int ch = 0; ch < int'(WIDTH); ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign o_data       = data_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_evt_sticky = evt_q;

endmodule

// File: tb/tb_com_cdc_synch_filt.sv
// Directed bench for com_cdc_synch_filt: reset-value instance, default
// instance and a NUM_STAGES=3/FILTER_LEN=1 instance.
module tb_com_cdc_synch_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance with RESET_VALUE = 8'hA5
  logic       r_rst;
  logic [7:0] r_data, r_clr;
  logic [7:0] r_odata, r_rise, r_fall, r_evt;
  // Default instance
  logic       d_rst;
  logic [7:0] d_data, d_clr;
  logic [7:0] d_odata, d_rise, d_fall, d_evt;
  // Sweep instance
  logic       s_rst;
  logic [7:0] s_data, s_clr;
  logic [7:0] s_odata, s_rise, s_fall, s_evt;

  logic [7:0] acc;

  com_cdc_synch_filt #(.WIDTH(8), .NUM_STAGES(2), .FILTER_LEN(3), .RESET_VALUE(8'hA5)) u_rst (
    .i_clk(clk), .i_rst(r_rst), .i_data(r_data), .i_clear_evt(r_clr),
    .o_data(r_odata), .o_rise(r_rise), .o_fall(r_fall), .o_evt_sticky(r_evt));

  com_cdc_synch_filt #(.WIDTH(8), .NUM_STAGES(2), .FILTER_LEN(3), .RESET_VALUE(8'h00)) u_dut (
    .i_clk(clk), .i_rst(d_rst), .i_data(d_data), .i_clear_evt(d_clr),
    .o_data(d_odata), .o_rise(d_rise), .o_fall(d_fall), .o_evt_sticky(d_evt));

  com_cdc_synch_filt #(.WIDTH(8), .NUM_STAGES(3), .FILTER_LEN(1), .RESET_VALUE(8'h00)) u_sw (
    .i_clk(clk), .i_rst(s_rst), .i_data(s_data), .i_clear_evt(s_clr),
    .o_data(s_odata), .o_rise(s_rise), .o_fall(s_fall), .o_evt_sticky(s_evt));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    r_rst = 1'b1; r_data = 8'h00; r_clr = 8'h00;
    d_rst = 1'b1; d_data = 8'h00; d_clr = 8'h00;
    s_rst = 1'b1; s_data = 8'h00; s_clr = 8'h00;

    // ---- Reset value and first fall
    tick(3);
    r_rst = 1'b0;
    d_rst = 1'b0;
    check("rst_data", r_odata, 8'hA5);
    check("rst_rise", r_rise,  8'h00);
    check("rst_fall", r_fall,  8'h00);
    check("rst_evt",  r_evt,   8'h00);
    tick(4);
    check("rst_hold4", r_odata, 8'hA5);
    check("rst_nofall4", r_fall, 8'h00);
    tick(1);
    check("rst_fall5_data", r_odata, 8'h00);
    check("rst_fall5_strobe", r_fall, 8'hA5);
    check("rst_fall5_rise", r_rise, 8'h00);
    tick(1);
    check("rst_fall6_strobe", r_fall, 8'h00);
    check("rst_evt6", r_evt, 8'hA5);

    // ---- Latency on channel 0
    check("lat_init", d_odata, 8'h00);
    d_data = 8'h01;
    tick(4);
    check("lat_before", d_odata, 8'h00);
    tick(1);
    check("lat_data", d_odata, 8'h01);
    check("lat_rise", d_rise,  8'h01);
    tick(1);
    check("lat_rise_once", d_rise, 8'h00);
    check("lat_evt", d_evt, 8'h01);

    // ---- Glitch reject: 2-cycle pulse on channel 3
    d_data = 8'h09;
    tick(2);
    d_data = 8'h01;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      acc = acc | d_rise | d_fall | (d_odata & 8'h08);
    end
    check("glitch_activity", acc, 8'h00);
    check("glitch_data", d_odata, 8'h01);
    check("glitch_evt", d_evt, 8'h01);

    // ---- 3-cycle pulse on channel 3 passes for exactly 3 cycles
    d_data = 8'h09;
    tick(3);
    d_data = 8'h01;
    tick(1);
    check("pulse3_pre", d_odata, 8'h01);
    tick(1);
    check("pulse3_data_e4", d_odata, 8'h09);
    check("pulse3_rise", d_rise, 8'h08);
    tick(1);
    check("pulse3_data_e5", d_odata, 8'h09);
    check("pulse3_rise_once", d_rise, 8'h00);
    check("pulse3_evt", d_evt, 8'h09);
    tick(1);
    check("pulse3_data_e6", d_odata, 8'h09);
    tick(1);
    check("pulse3_data_e7", d_odata, 8'h01);
    check("pulse3_fall", d_fall, 8'h08);
    tick(1);
    check("pulse3_fall_once", d_fall, 8'h00);

    // ---- Sticky clear race on channel 1
    d_data = 8'h03;
    tick(5);
    check("race_rise", d_rise, 8'h02);
    check("race_evt_set", d_evt, 8'h0B);
    d_data = 8'h01;
    tick(4);
    d_clr = 8'h02;
    tick(1);
    d_clr = 8'h00;
    check("race_fall", d_fall, 8'h02);
    check("race_evt_kept", d_evt, 8'h0B);
    tick(1);
    check("race_evt_after", d_evt, 8'h0B);
    d_clr = 8'h02;
    tick(1);
    d_clr = 8'h00;
    check("clear_alone", d_evt, 8'h09);

    // ---- Reset mid-count on channel 5, then independent channels
    d_clr = 8'hFF;
    tick(1);
    d_clr = 8'h00;
    check("clear_all", d_evt, 8'h00);
    d_data = 8'h21;
    tick(3);
    d_rst = 1'b1;
    tick(1);
    d_rst = 1'b0;
    check("midrst_data", d_odata, 8'h00);
    check("midrst_strobes", d_rise | d_fall, 8'h00);
    check("midrst_evt", d_evt, 8'h00);
    tick(1);
    d_data = 8'hA1;
    tick(1);
    d_data = 8'hA5;
    tick(2);
    check("indep_before", d_odata, 8'h00);
    tick(1);
    check("indep_ch0_5", d_odata, 8'h21);
    check("indep_rise_0_5", d_rise, 8'h21);
    tick(1);
    check("indep_ch7", d_odata, 8'hA1);
    check("indep_rise_7", d_rise, 8'h80);
    tick(1);
    check("indep_ch2", d_odata, 8'hA5);
    check("indep_rise_2", d_rise, 8'h04);
    check("indep_evt", d_evt, 8'hA5);
    d_data = 8'h5A;
    tick(4);
    check("toggle_before", d_odata, 8'hA5);
    tick(1);
    check("toggle_data", d_odata, 8'h5A);
    check("toggle_rise", d_rise, 8'h5A);
    check("toggle_fall", d_fall, 8'hA5);
    check("toggle_evt", d_evt, 8'hFF);

    // ---- Sweep: NUM_STAGES=3, FILTER_LEN=1
    tick(1);
    s_rst = 1'b0;
    check("sw_reset", s_odata, 8'h00);
    s_data = 8'h01;
    tick(3);
    check("sw_lat_before", s_odata, 8'h00);
    tick(1);
    check("sw_lat_data", s_odata, 8'h01);
    check("sw_lat_rise", s_rise, 8'h01);
    tick(1);
    s_data = 8'h05;
    tick(1);
    s_data = 8'h01;
    tick(2);
    check("sw_pulse_pre", s_odata, 8'h01);
    tick(1);
    check("sw_pulse_data", s_odata, 8'h05);
    check("sw_pulse_rise", s_rise, 8'h04);
    tick(1);
    check("sw_pulse_end", s_odata, 8'h01);
    check("sw_pulse_fall", s_fall, 8'h04);
    check("sw_pulse_norise", s_rise, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
